// File: rtl/alarm_event_scheduler.sv
// Smoke/temperature/overload alarm supervisor: sensor sync + debounce, sticky
// pending flags, EN sequencing with minimum on-time, ACK handling and display rotation.
module alarm_event_scheduler #(
    parameter int DEB_CYCLES  = 16,
    parameter int HOLD_CYCLES = 100,
    parameter int ROT_CYCLES  = 50
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       HUMO,
    input  logic       TEMP,
    input  logic       SOBRECARGA,
    input  logic       ACK,
    output logic       EN,
    output logic [1:0] ALARM_ID,
    output logic [2:0] PENDING,
    output logic [7:0] ESTADO_7SEG
);

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int RW = (ROT_CYCLES > 1) ? $clog2(ROT_CYCLES) : 1;
    localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_CYCLES);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);
    localparam logic [RW-1:0] ROT_MAX  = RW'(ROT_CYCLES - 1);
    localparam logic [1:0]    ID_NONE  = 2'd3;
    localparam logic [7:0]    SEG_IDLE = 8'b1000_0001;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ALARM    = 2'd1,
        WAIT_ACK = 2'd2
    } state_t;

    state_t               state, state_next;
    logic [2:0]           raw, sync1, sync2;
    logic [2:0][DW-1:0]   deb_cnt;
    logic [2:0]           act, act_next;
    logic [2:0]           pending, pending_next;
    logic [HW-1:0]        hold;
    logic [RW-1:0]        rot;
    logic [1:0]           alarm_id;
    logic [7:0]           seg, seg_next;
    logic                 id_ok;

    assign raw = {SOBRECARGA, TEMP, HUMO};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            deb_cnt <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!sync2[i])
                    deb_cnt[i] <= '0;
                else if (deb_cnt[i] != DEB_MAX)
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
            end
        end
    end

    // act_next looks one edge ahead so PENDING sets on the same edge act rises.
    always_comb begin
        act      = '0;
        act_next = '0;
        for (int i = 0; i < 3; i++) begin
            act[i]      = (deb_cnt[i] == DEB_MAX);
            act_next[i] = sync2[i] && (deb_cnt[i] >= DEB_MAX - 1'b1);
        end
    end

    always_comb begin
        pending_next = pending;
        for (int i = 0; i < 3; i++) begin
            if (act_next[i])
                pending_next[i] = 1'b1;
            else if (ACK && !act[i])
                pending_next[i] = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) pending <= '0;
        else     pending <= pending_next;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (pending != 3'b000) state_next = ALARM;
            ALARM:    if (hold == HOLD_MAX && act == 3'b000) state_next = WAIT_ACK;
            WAIT_ACK: begin
                if (act != 3'b000)          state_next = ALARM;
                else if (pending == 3'b000) state_next = IDLE;
            end
            default:  state_next = IDLE;
        endcase
    end

    // Hold counter restarts on every entry into ALARM and saturates at the end.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            hold <= '0;
        else if (state == ALARM && state_next == ALARM) begin
            if (hold != HOLD_MAX) hold <= hold + 1'b1;
        end else
            hold <= '0;
    end

    function automatic logic [1:0] inc3(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    function automatic logic [1:0] prio_id(input logic [2:0] p);
        if (p[0])      return 2'd0;
        else if (p[1]) return 2'd1;
        else if (p[2]) return 2'd2;
        else           return ID_NONE;
    endfunction

    // Next pending source cyclically after cur; cur itself only as last resort.
    function automatic logic [1:0] next_id(input logic [2:0] p, input logic [1:0] cur);
        logic [1:0] c1, c2;
        if (cur == ID_NONE) return prio_id(p);
        c1 = inc3(cur);
        c2 = inc3(c1);
        if (p[c1])       return c1;
        else if (p[c2])  return c2;
        else if (p[cur]) return cur;
        else             return ID_NONE;
    endfunction

    assign id_ok = (alarm_id != ID_NONE) && pending[alarm_id];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            alarm_id <= ID_NONE;
            rot      <= '0;
        end else if (state_next == IDLE) begin
            alarm_id <= ID_NONE;
            rot      <= '0;
        end else if (state == IDLE) begin
            alarm_id <= prio_id(pending);
            rot      <= '0;
        end else if (!id_ok) begin
            alarm_id <= next_id(pending, alarm_id);
            rot      <= '0;
        end else if (rot == ROT_MAX) begin
            alarm_id <= next_id(pending, alarm_id);
            rot      <= '0;
        end else begin
            rot <= rot + 1'b1;
        end
    end

    always_comb begin
        seg_next = SEG_IDLE;
        if (state == ALARM || state == WAIT_ACK) begin
            seg_next[7] = (state == ALARM);
            case (alarm_id)
                2'd0:    seg_next[6:0] = 7'b1001111;
                2'd1:    seg_next[6:0] = 7'b0010010;
                2'd2:    seg_next[6:0] = 7'b0000110;
                default: seg_next[6:0] = 7'b0000001;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) seg <= SEG_IDLE;
        else     seg <= seg_next;
    end

    assign EN          = (state == ALARM);
    assign ALARM_ID    = alarm_id;
    assign PENDING     = pending;
    assign ESTADO_7SEG = seg;

endmodule
